// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: valid/ready byte FIFO feeding a run-time configured
// serialiser (baud divisor, parity mode, 1/2 stop bits) with CTS gating and TX enable.
module uart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             s_valid,
  input  logic [DATA_W-1:0]                s_data,
  output logic                             s_ready,
  input  logic [DIV_W-1:0]                 cfg_baud_div,
  input  logic [1:0]                       cfg_parity,
  input  logic                             cfg_two_stop,
  input  logic                             tx_en,
  input  logic                             cts_n,
  output logic                             tx,
  output logic                             busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH+1);
  localparam int BW = $clog2(DATA_W+1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              push, pop;

  logic [1:0]        cts_s;
  logic              cts_ok, start_ok, bit_end, last_stop;

  state_t            state;
  logic [DIV_W-1:0]  cnt, div_l, div_eff;
  logic [DATA_W-1:0] sh;
  logic [BW-1:0]     bitcnt;
  logic [1:0]        par_l;
  logic              two_l, stop2, pbit;

  function automatic logic par_of(input logic [DATA_W-1:0] d, input logic [1:0] mode);
    case (mode)
      2'd1:    par_of = ^d;
      2'd2:    par_of = ~^d;
      2'd3:    par_of = 1'b1;
      default: par_of = 1'b0;
    endcase
  endfunction

  // ---------------- FIFO ----------------
  assign s_ready = (fifo_level != LW'(FIFO_DEPTH));
  assign push    = s_valid && s_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: ;
      endcase
    end
  end

  // ---------------- CTS synchroniser (resets to "not clear") ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cts_s <= 2'b11;
    else        cts_s <= {cts_s[0], cts_n};
  end
  assign cts_ok = ~cts_s[1];

  // ---------------- Serialiser ----------------
  assign div_eff   = (cfg_baud_div < DIV_W'(2)) ? DIV_W'(2) : cfg_baud_div;
  assign start_ok  = (fifo_level != '0) && tx_en && cts_ok;
  assign bit_end   = (cnt == '0);
  assign last_stop = (state == STOP) && bit_end && (!two_l || stop2);
  // A new frame can start from IDLE or directly off the last stop bit (no gap).
  assign pop       = start_ok && ((state == IDLE) || last_stop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      tx     <= 1'b1;
      busy   <= 1'b0;
      cnt    <= '0;
      div_l  <= DIV_W'(2);
      sh     <= '0;
      bitcnt <= '0;
      par_l  <= 2'd0;
      two_l  <= 1'b0;
      stop2  <= 1'b0;
      pbit   <= 1'b0;
    end else if (pop) begin
      state  <= START;
      tx     <= 1'b0;
      busy   <= 1'b1;
      sh     <= mem[rd_ptr];
      pbit   <= par_of(mem[rd_ptr], cfg_parity);
      div_l  <= div_eff;
      par_l  <= cfg_parity;
      two_l  <= cfg_two_stop;
      cnt    <= div_eff - DIV_W'(1);
      bitcnt <= '0;
      stop2  <= 1'b0;
    end else begin
      if (state != IDLE) cnt <= bit_end ? div_l - DIV_W'(1) : cnt - DIV_W'(1);
      if (bit_end) begin
        case (state)
          IDLE: begin
            tx   <= 1'b1;
            busy <= 1'b0;
          end
          START: begin
            state  <= DATA;
            tx     <= sh[0];
            sh     <= sh >> 1;
            bitcnt <= '0;
          end
          DATA: begin
            if (bitcnt == BW'(DATA_W-1)) begin
              state <= (par_l != 2'd0) ? PARITY : STOP;
              tx    <= (par_l != 2'd0) ? pbit : 1'b1;
              stop2 <= 1'b0;
            end else begin
              tx     <= sh[0];
              sh     <= sh >> 1;
              bitcnt <= bitcnt + BW'(1);
            end
          end
          PARITY: begin
            state <= STOP;
            tx    <= 1'b1;
            stop2 <= 1'b0;
          end
          STOP: begin
            if (two_l && !stop2) stop2 <= 1'b1;
            else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed scenarios plus randomized bursts, checked
// against a bit-list frame model and a byte queue.
module tb_uart_tx_fifo;
  localparam int DW = 8;
  localparam int DEPTH = 16;

  logic       clk = 0, rst_n = 0;
  logic       s_valid = 0, s_ready;
  logic [7:0] s_data = '0;
  logic [15:0] cfg_baud_div = 16'd4;
  logic [1:0] cfg_parity = 0;
  logic       cfg_two_stop = 0, tx_en = 0, cts_n = 0;
  logic       tx, busy;
  logic [4:0] fifo_level;

  int pass_cnt = 0, total = 0;
  logic [7:0] q[$];
  bit   fbits[16];
  int   fn;

  uart_tx_fifo #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .DIV_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .cfg_baud_div(cfg_baud_div), .cfg_parity(cfg_parity), .cfg_two_stop(cfg_two_stop),
    .tx_en(tx_en), .cts_n(cts_n), .tx(tx), .busy(busy), .fifo_level(fifo_level));

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  // Frame as a list of line levels, one entry per bit period.
  task automatic build_frame(input logic [7:0] d, input int par, input bit two);
    fn = 0;
    fbits[fn++] = 0;
    for (int i = 0; i < DW; i++) fbits[fn++] = d[i];
    if (par == 1) fbits[fn++] = ^d;
    else if (par == 2) fbits[fn++] = ~^d;
    else if (par == 3) fbits[fn++] = 1;
    fbits[fn++] = 1;
    if (two) fbits[fn++] = 1;
  endtask

  task automatic push(input logic [7:0] d, output bit acc);
    s_valid = 1; s_data = d; acc = s_ready;
    step(1);
    s_valid = 0;
  endtask

  task automatic wait_start(input int limit, input string name);
    int w = 0;
    while (!(busy === 1'b1 && tx === 1'b0) && w < limit) begin step(1); w++; end
    total++;
    if (w >= limit) $display("FAIL %s start: no frame start within %0d cycles", name, limit);
    else pass_cnt++;
  endtask

  task automatic expect_frame(input logic [7:0] d, input int div, input int par,
                              input bit two, input string name);
    int de, bad, first_k;
    logic first_tx;
    de = (div < 2) ? 2 : div;
    build_frame(d, par, two);
    bad = 0; first_k = -1; first_tx = 1'bx;
    for (int k = 0; k < fn * de; k++) begin
      if (tx !== fbits[k / de] || busy !== 1'b1) begin
        if (bad == 0) begin first_k = k; first_tx = tx; end
        bad++;
      end
      step(1);
    end
    total++;
    if (bad != 0)
      $display("FAIL %s frame d=%h: %0d bad clocks, first at clk %0d tx=%b busy=%b required tx=%b",
               name, d, bad, first_k, first_tx, busy, fbits[first_k / de]);
    else pass_cnt++;
  endtask

  task automatic check_idle(input string name);
    total++;
    if (busy !== 1'b0 || tx !== 1'b1)
      $display("FAIL %s idle: busy=%b tx=%b required busy=0 tx=1", name, busy, tx);
    else pass_cnt++;
  endtask

  task automatic test_reset;
    total++;
    if (tx !== 1 || busy !== 0 || fifo_level !== 0 || s_ready !== 1)
      $display("FAIL reset: tx=%b busy=%b level=%0d ready=%b required 1 0 0 1",
               tx, busy, fifo_level, s_ready);
    else pass_cnt++;
  endtask

  task automatic test_even_parity;
    bit a;
    cfg_baud_div = 4; cfg_parity = 1; cfg_two_stop = 0; tx_en = 1; cts_n = 0;
    push(8'hA5, a);
    wait_start(10, "even");
    expect_frame(8'hA5, 4, 1, 0, "even");
    check_idle("even");
  endtask

  task automatic test_odd_two_stop;
    bit a;
    cfg_baud_div = 3; cfg_parity = 2; cfg_two_stop = 1;
    push(8'h07, a);
    wait_start(10, "odd2");
    expect_frame(8'h07, 3, 2, 1, "odd2");
    check_idle("odd2");
  endtask

  task automatic test_fill_cts;
    bit a; int nacc, txbad;
    cts_n = 1; cfg_baud_div = 2; cfg_parity = 0; cfg_two_stop = 0; tx_en = 1;
    step(3);
    nacc = 0; txbad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [7:0] d = 8'($urandom);
      push(d, a);
      if (a) begin nacc++; q.push_back(d); end
      if (tx !== 1 || busy !== 0) txbad++;
    end
    total++;
    if (nacc != DEPTH || fifo_level !== 5'(DEPTH) || s_ready !== 0)
      $display("FAIL fill: accepted=%0d level=%0d ready=%b required %0d %0d 0",
               nacc, fifo_level, s_ready, DEPTH, DEPTH);
    else pass_cnt++;
    push(8'h5A, a);
    step(4);
    total++;
    if (a || fifo_level !== 5'(DEPTH) || tx !== 1 || txbad != 0)
      $display("FAIL overflow: accepted=%b level=%0d tx=%b txbad=%0d required 0 %0d 1 0",
               a, fifo_level, tx, txbad, DEPTH);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    // Offer a word while full: it must be refused even on the pop edge.
    s_valid = 1; s_data = 8'hEE;
    cts_n = 0;
    wait_start(10, "drain");
    s_valid = 0;
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (busy !== 1 || tx !== 0 || fifo_level !== 5'(DEPTH - 1 - i))
        $display("FAIL drain%0d start: busy=%b tx=%b level=%0d required 1 0 %0d",
                 i, busy, tx, fifo_level, DEPTH - 1 - i);
      else pass_cnt++;
      expect_frame(q.pop_front(), 2, 0, 0, "drain");
    end
    check_idle("drain");
    total++;
    if (fifo_level !== 0) $display("FAIL drain level: %0d required 0", fifo_level);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    bit a;
    tx_en = 0; cfg_baud_div = 4; cfg_parity = 0; cfg_two_stop = 0;
    push(8'h00, a); push(8'h11, a); push(8'h22, a);
    tx_en = 1;
    wait_start(10, "rstmid");
    step(18);
    #2 rst_n = 0;
    #1;
    total++;
    if (tx !== 1 || busy !== 0 || fifo_level !== 0 || s_ready !== 1)
      $display("FAIL rstmid async: tx=%b busy=%b level=%0d ready=%b required 1 0 0 1",
               tx, busy, fifo_level, s_ready);
    else pass_cnt++;
    @(posedge clk); #1 rst_n = 1;
    step(3);
    push(8'h3C, a);
    wait_start(10, "rstmid");
    expect_frame(8'h3C, 4, 0, 0, "rstmid");
    check_idle("rstmid");
  endtask

  task automatic test_cfg_change;
    bit a;
    tx_en = 0; cfg_baud_div = 4; cfg_parity = 0; cfg_two_stop = 0;
    push(8'h96, a); push(8'h3B, a);
    tx_en = 1;
    wait_start(10, "cfg");
    cfg_baud_div = 8;
    expect_frame(8'h96, 4, 0, 0, "cfg_old");
    expect_frame(8'h3B, 8, 0, 0, "cfg_new");
    check_idle("cfg");
  endtask

  task automatic test_cts_mid;
    bit a;
    tx_en = 0; cfg_baud_div = 2; cfg_parity = 3; cfg_two_stop = 0;
    push(8'h81, a); push(8'h42, a);
    tx_en = 1;
    wait_start(10, "cts");
    cts_n = 1;
    expect_frame(8'h81, 2, 3, 0, "cts_cur");
    step(5);
    total++;
    if (busy !== 0 || tx !== 1 || fifo_level !== 1)
      $display("FAIL cts hold: busy=%b tx=%b level=%0d required 0 1 1", busy, tx, fifo_level);
    else pass_cnt++;
    cts_n = 0;
    wait_start(10, "cts");
    expect_frame(8'h42, 2, 3, 0, "cts_next");
    check_idle("cts");
  endtask

  task automatic test_random;
    bit a; int div, par, n; bit two;
    for (int it = 0; it < 6; it++) begin
      div = int'($urandom_range(5, 0)); par = int'($urandom_range(3, 0));
      two = 1'($urandom); n = int'($urandom_range(4, 1));
      cfg_baud_div = 16'(div); cfg_parity = 2'(par); cfg_two_stop = two;
      tx_en = 0;
      for (int i = 0; i < n; i++) begin
        logic [7:0] d = 8'($urandom);
        push(d, a);
        if (a) q.push_back(d);
      end
      tx_en = 1;
      wait_start(10, "rand");
      while (q.size() > 0) expect_frame(q.pop_front(), div, par, two, "rand");
      check_idle("rand");
    end
  endtask

  initial begin
    step(3);
    test_reset;
    rst_n = 1;
    step(3);
    test_even_parity;
    test_odd_two_stop;
    test_fill_cts;
    test_back_to_back;
    test_reset_mid;
    test_cfg_change;
    test_cts_mid;
    test_random;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
